// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, the two-word C-field marker and the fetch state encoding.
package cpu_pkg;

   localparam logic [3:0] OpMov  = 4'd0;
   localparam logic [3:0] OpAdd  = 4'd1;
   localparam logic [3:0] OpSub  = 4'd2;
   localparam logic [3:0] OpAnd  = 4'd3;
   localparam logic [3:0] OpOr   = 4'd4;
   localparam logic [3:0] OpLoad = 4'd5;
   localparam logic [3:0] OpJump = 4'd6;
   localparam logic [3:0] OpStop = 4'd7;

   localparam logic [3:0] TwoWordC = 4'b1000;

   typedef enum logic [2:0] {
      StAddrHi,
      StWaitHi,
      StAddrLo,
      StWaitLo,
      StHold,
      StHalt
   } fetch_state_e;

   // MOV with C == 4'b1000 carries an extra immediate word.
   function automatic logic is_two_word(input logic [3:0] op, input logic [3:0] c);
      return (op == OpMov) && (c == TwoWordC);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_reg.sv
// Generic enabled register with synchronous active-high reset to a fixed value.
module instr_fetch_unit_reg #(
   parameter int unsigned       WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RESET_VAL;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetches one- or two-word instructions from a fixed-latency memory and offers them
// through a valid/ready handshake; supports redirects and a STOP halt.
module instr_fetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 6,
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned MEM_LATENCY = 1,
   parameter int unsigned PC_RESET    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] mem_in,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] instr_hi,
   output logic [DATA_WIDTH-1:0] instr_lo,
   output logic                  instr_two_word,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  halted
);

   localparam int unsigned CntW = $clog2(MEM_LATENCY + 2);
   localparam logic [CntW-1:0] CntLast = CntW'(MEM_LATENCY);

   fetch_state_e          state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  pc_en, mar_en, ipc_en, cap_hi, cap_lo;
   logic [ADDR_WIDTH-1:0] pc_d;
   logic                  mem_two_word;

   assign mem_two_word = is_two_word(mem_in[DATA_WIDTH-1:DATA_WIDTH-4], mem_in[3:0]);

   instr_fetch_unit_reg #(
      .WIDTH     (ADDR_WIDTH),
      .RESET_VAL (ADDR_WIDTH'(PC_RESET))
   ) u_pc (
      .clk (clk),
      .rst (rst),
      .en  (pc_en),
      .d   (pc_d),
      .q   (pc)
   );

   instr_fetch_unit_reg #(
      .WIDTH     (ADDR_WIDTH),
      .RESET_VAL ('0)
   ) u_mar (
      .clk (clk),
      .rst (rst),
      .en  (mar_en),
      .d   (pc),
      .q   (mem_addr)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_en   = 1'b0;
      pc_d    = pc + ADDR_WIDTH'(1);
      mar_en  = 1'b0;
      ipc_en  = 1'b0;
      cap_hi  = 1'b0;
      cap_lo  = 1'b0;
      if (redirect_valid) begin
         // Redirect wins over everything; any partially fetched instruction is dropped.
         state_d = StAddrHi;
         cnt_d   = '0;
         pc_en   = 1'b1;
         pc_d    = redirect_pc;
      end else begin
         unique case (state_q)
            StAddrHi: begin
               mar_en  = 1'b1;
               pc_en   = 1'b1;
               ipc_en  = 1'b1;
               cnt_d   = '0;
               state_d = StWaitHi;
            end
            StWaitHi: begin
               if (cnt_q == CntLast) begin
                  cap_hi  = 1'b1;
                  cnt_d   = '0;
                  state_d = mem_two_word ? StAddrLo : StHold;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StAddrLo: begin
               mar_en  = 1'b1;
               pc_en   = 1'b1;
               cnt_d   = '0;
               state_d = StWaitLo;
            end
            StWaitLo: begin
               if (cnt_q == CntLast) begin
                  cap_lo  = 1'b1;
                  cnt_d   = '0;
                  state_d = StHold;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StHold: begin
               if (instr_ready) begin
                  state_d = (instr_hi[DATA_WIDTH-1:DATA_WIDTH-4] == OpStop) ? StHalt : StAddrHi;
               end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StAddrHi;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StAddrHi;
         cnt_q          <= '0;
         instr_hi       <= '0;
         instr_lo       <= '0;
         instr_pc       <= '0;
         instr_two_word <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (ipc_en) begin
            instr_pc <= pc;
         end
         if (cap_hi) begin
            instr_hi       <= mem_in;
            instr_two_word <= mem_two_word;
         end
         if (cap_lo) begin
            instr_lo <= mem_in;
         end
      end
   end

   assign instr_valid = (state_q == StHold);
   assign halted      = (state_q == StHalt);

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, meaning memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, minimum 16, meaning memory word width.
REQ-003 SHALL have parameter MEM_LATENCY, default 1, range 0..6, meaning cycles from mem_addr change to valid mem_in, minus one.
REQ-004 SHALL have parameter PC_RESET, default 8, meaning first fetch address.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port mem_in, input, DATA_WIDTH, meaning memory read data.
REQ-008 SHALL have port mem_addr, output, ADDR_WIDTH, meaning registered fetch address.
REQ-009 SHALL have port pc, output, ADDR_WIDTH, meaning next fetch address.
REQ-010 SHALL have port instr_valid, output, 1, meaning an instruction is offered.
REQ-011 SHALL have port instr_ready, input, 1, meaning the consumer accepts the instruction.
REQ-012 SHALL have ports instr_hi and instr_lo, output, DATA_WIDTH each, meaning the first and second instruction words.
REQ-013 SHALL have port instr_two_word, output, 1, meaning instr_lo is meaningful.
REQ-014 SHALL have port instr_pc, output, ADDR_WIDTH, meaning the address of instr_hi.
REQ-015 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, ADDR_WIDTH), meaning a jump request.
REQ-016 SHALL have port halted, output, 1, meaning a STOP instruction was accepted.

Function
REQ-017 SHALL decode the opcode as word[DATA_WIDTH-1:DATA_WIDTH-4] and the C operand as word[3:0].
REQ-018 SHALL treat a word as two-word when opcode==MOV(0) and C==4'b1000; otherwise one-word.
REQ-019 SHALL implement the states ADDR_HI, WAIT_HI, ADDR_LO, WAIT_LO, HOLD and HALT.
REQ-020 In ADDR_x it SHALL load mar<=pc and pc<=pc+1 (mod 2^ADDR_WIDTH), then go to WAIT_x.
REQ-021 WAIT_x SHALL last exactly MEM_LATENCY+1 cycles, with mem_addr stable throughout.
REQ-022 On the last WAIT_x edge it SHALL capture mem_in into instr_hi or instr_lo.
REQ-023 After WAIT_HI it SHALL go to ADDR_LO if the captured word is two-word, else to HOLD.
REQ-024 After WAIT_LO it SHALL go to HOLD.
REQ-025 If ADDR_HI occurs in cycle 0, instr_valid SHALL rise in cycle MEM_LATENCY+2 (one-word) or 2*MEM_LATENCY+4 (two-word).
REQ-026 instr_valid SHALL be 1 only in HOLD.
REQ-027 All instr_* outputs SHALL stay stable while instr_valid&&!instr_ready.
REQ-028 When HOLD and instr_ready both hold, the instruction SHALL transfer.
REQ-029 On transfer, the block SHALL go to HALT if the opcode is STOP(7), else to ADDR_HI.
REQ-030 instr_two_word SHALL be 0 and instr_lo SHALL be unchanged for a one-word instruction.
REQ-031 In HALT it SHALL keep instr_valid=0 and halted=1, perform no memory activity, and hold pc.
REQ-032 redirect_valid SHALL override all other state logic except rst, in any state.
REQ-033 On redirect it SHALL set pc<=redirect_pc, discard any partial fetch, clear halted, and go to ADDR_HI; instr_valid SHALL be 0 next cycle.
REQ-034 On redirect in HOLD with instr_ready=1, the current instruction SHALL count as transferred, and the next fetch SHALL come from redirect_pc, even if the instruction is STOP.
REQ-035 The low-word fetch SHALL wrap: hi at address 2^ADDR_WIDTH-1 gives lo at address 0.

Reset
REQ-036 While rst=1 at a rising edge, the block SHALL set state=ADDR_HI, pc=PC_RESET, mem_addr=0, instr_valid=0, instr_hi=0, instr_lo=0, instr_pc=0, instr_two_word=0, halted=0, and clear the wait counter.
REQ-037 rst asserted mid-fetch or mid-HOLD SHALL abort with no transfer.
REQ-038 The first ADDR_HI SHALL occur in the first cycle after rst is released.

Structure
REQ-039 A shared package cpu_pkg SHALL hold the opcode constants (MOV..STOP), the fetch state encoding, and the two-word C-field constant 4'b1000.
REQ-040 pc and mar SHALL be instances of the existing register sub-module; the FSM, the wait counter ($clog2(MEM_LATENCY+2) bits) and the instruction registers SHALL be local.

Verification
REQ-041 Reset, MEM_LATENCY=1, mem[8]=16'h3123, instr_ready=1 -> mem_addr=8 from cycle 1, instr_valid in cycle 3, instr_hi=16'h3123, instr_pc=8, two_word=0, pc=9.
REQ-042 mem[8]=16'h0128, mem[9]=16'hBEEF, MEM_LATENCY=1 -> instr_valid in cycle 6, instr_hi=16'h0128, instr_lo=16'hBEEF, two_word=1, pc=10.
REQ-043 instr_ready=0 for 5 cycles during HOLD -> outputs constant, no mem_addr change, exactly one transfer once instr_ready=1.
REQ-044 mem[8]=16'h7000 accepted -> halted=1, instr_valid=0 permanently; then redirect_pc=20 -> halted=0, mem_addr=20.
REQ-045 redirect_valid with redirect_pc=30 in WAIT_LO -> partial instruction dropped, next instr_pc=30.
REQ-046 pc=63 holding 16'h0008, mem[0]=16'h1234, MEM_LATENCY=0 and 3 -> instr_lo=16'h1234, pc=1, with valid timing per REQ-025.
